// File: rtl/nvme_queue_pkg.sv
// Shared types, doorbell FSM encoding and doorbell address helper for nvme_queue_ctrl.
package nvme_queue_pkg;

    localparam logic [31:0] DB_BASE_DEFAULT = 32'h0000_1000;

    typedef logic [3:0]  qid_t;   // holds any queue id up to 16 queue pairs
    typedef logic [15:0] ptr_t;   // NVMe queue pointers never exceed 16 bits

    typedef enum logic {
        DB_IDLE,
        DB_WRITE
    } db_state_e;

    // Doorbells are laid out SQ0 tail, CQ0 head, SQ1 tail, ... each (4 << dstrd) bytes apart.
    function automatic logic [31:0] db_offset(input qid_t q, input logic is_cq, input int unsigned dstrd);
        return {27'd0, q, is_cq} << (2 + dstrd);
    endfunction

endpackage

// File: rtl/nvme_rr_arbiter.sv
// Rotating-priority arbiter: the requester at or after the pointer wins; pointer moves on advance.
module nvme_rr_arbiter #(
    parameter int unsigned N = 2,
    localparam int unsigned IW = (N > 1) ? $clog2(N) : 1
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic [N-1:0]  req,
    input  logic          advance,
    output logic [N-1:0]  grant,
    output logic [IW-1:0] idx
);

    logic [IW-1:0] ptr;
    logic [IW-1:0] cand;

    // NOTE: every always_comb output gets a default first so no path leaves a latch behind.
    always_comb begin
        grant = '0;
        idx   = '0;
        cand  = '0;
        // Scan downwards so the candidate closest to the pointer is written last and wins.
        for (int i = N - 1; i >= 0; i--) begin
            cand = IW'((32'(ptr) + 32'(i)) % N);
            if (req[cand]) begin
                idx         = cand;
                grant       = '0;
                grant[cand] = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if (advance) begin
            ptr <= (idx == IW'(N - 1)) ? '0 : idx + 1'b1;
        end
    end

endmodule

// File: rtl/nvme_queue_ctrl.sv
// NVMe SQ/CQ pointer tracking with slot allocation and coalesced, one-at-a-time doorbell writes.
module nvme_queue_ctrl
    import nvme_queue_pkg::*;
#(
    parameter int unsigned NUM_Q   = 4,
    parameter int unsigned Q_DEPTH = 8,
    parameter logic [31:0] DB_BASE = DB_BASE_DEFAULT,
    parameter int unsigned DSTRD   = 0,
    localparam int unsigned QW = (NUM_Q > 1) ? $clog2(NUM_Q) : 1,
    localparam int unsigned PW = $clog2(Q_DEPTH)
) (
    input  logic                  axi_aclk,
    input  logic                  axi_aresetn,
    input  logic                  alloc_valid,
    input  logic [QW-1:0]         alloc_qid,
    output logic                  alloc_ready,
    output logic [PW-1:0]         alloc_slot,
    input  logic                  cpl_valid,
    input  logic [QW-1:0]         cpl_qid,
    input  logic [PW-1:0]         cpl_sqhd,
    output logic                  cpl_ready,
    output logic [NUM_Q-1:0]      cq_phase,
    output logic [NUM_Q*PW-1:0]   cq_head,
    output logic                  pcie_write,
    output logic [31:0]           pcie_waddr,
    output logic [31:0]           pcie_wdata,
    input  logic                  pcie_wdone,
    input  logic                  pcie_werror,
    output logic [NUM_Q-1:0]      db_error
);

    localparam int unsigned NR = 2 * NUM_Q;
    localparam int unsigned IW = $clog2(NR);

    logic [PW-1:0]    sq_tail   [NUM_Q];
    logic [PW-1:0]    sq_head   [NUM_Q];
    logic [PW-1:0]    cq_head_r [NUM_Q];
    logic [NUM_Q-1:0] phase_r, sq_pend, cq_pend, err_r, full;
    logic [NR-1:0]    req, grant;
    logic [IW-1:0]    win_idx;
    logic [QW-1:0]    win_q, cur_q;
    logic             latch_en, alloc_ok, cpl_ok;
    logic [31:0]      waddr_r, wdata_r;
    db_state_e        state, state_nxt;

    // full compares against the registered head, so a same-cycle completion cannot free a slot early.
    always_comb begin
        full = '0;
        req  = '0;
        for (int q = 0; q < NUM_Q; q++) begin
            full[q]      = (PW'(sq_tail[q] + 1'b1) == sq_head[q]);
            req[2*q]     = sq_pend[q];
            req[2*q + 1] = cq_pend[q];
            cq_head[q*PW +: PW] = cq_head_r[q];
        end
    end

    assign alloc_ok    = alloc_valid && (32'(alloc_qid) < NUM_Q);
    assign cpl_ok      = cpl_valid && (32'(cpl_qid) < NUM_Q);
    assign alloc_ready = alloc_ok && !full[alloc_qid];
    assign alloc_slot  = sq_tail[alloc_qid];
    assign cpl_ready   = axi_aresetn;
    assign cq_phase    = phase_r;
    assign db_error    = err_r;
    assign win_q       = QW'(win_idx >> 1);

    nvme_rr_arbiter #(.N(NR)) u_arb (
        .clk     (axi_aclk),
        .rst_n   (axi_aresetn),
        .req     (req),
        .advance (latch_en),
        .grant   (grant),
        .idx     (win_idx)
    );

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) state <= DB_IDLE;
        else              state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        latch_en  = 1'b0;
        case (state)
            DB_IDLE: begin
                if (|req) begin
                    latch_en  = 1'b1;
                    state_nxt = DB_WRITE;
                end
            end
            DB_WRITE: if (pcie_wdone) state_nxt = DB_IDLE;
            default:  state_nxt = DB_IDLE;
        endcase
    end

    assign pcie_write = (state == DB_WRITE);
    assign pcie_waddr = waddr_r;
    assign pcie_wdata = wdata_r;

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            waddr_r <= '0;
            wdata_r <= '0;
            cur_q   <= '0;
        end else if (latch_en) begin
            waddr_r <= DB_BASE + db_offset(qid_t'(win_q), win_idx[0], DSTRD);
            wdata_r <= {16'd0, ptr_t'(win_idx[0] ? cq_head_r[win_q] : sq_tail[win_q])};
            cur_q   <= win_q;
        end
    end

    always_ff @(posedge axi_aclk or negedge axi_aresetn) begin
        if (!axi_aresetn) begin
            // NOTE: the pointer arrays are a handful of flops, not RAM, and must come out of reset at 0.
            for (int q = 0; q < NUM_Q; q++) begin
                sq_tail[q]   <= '0;
                sq_head[q]   <= '0;
                cq_head_r[q] <= '0;
            end
            phase_r <= '1;
            sq_pend <= '0;
            cq_pend <= '0;
            err_r   <= '0;
        end else begin
            for (int q = 0; q < NUM_Q; q++) begin
                if (latch_en && grant[2*q])     sq_pend[q] <= 1'b0;
                if (latch_en && grant[2*q + 1]) cq_pend[q] <= 1'b0;
            end
            // Sets come after the clears so an update racing the latch keeps its doorbell pending.
            if (alloc_ready) begin
                sq_tail[alloc_qid] <= sq_tail[alloc_qid] + 1'b1;
                sq_pend[alloc_qid] <= 1'b1;
            end
            if (cpl_ok) begin
                sq_head[cpl_qid]   <= cpl_sqhd;
                cq_head_r[cpl_qid] <= cq_head_r[cpl_qid] + 1'b1;
                if (cq_head_r[cpl_qid] == PW'(Q_DEPTH - 1)) phase_r[cpl_qid] <= ~phase_r[cpl_qid];
                cq_pend[cpl_qid]   <= 1'b1;
            end
            if (state == DB_WRITE && pcie_wdone && pcie_werror) err_r[cur_q] <= 1'b1;
        end
    end

endmodule
